// File: rtl/phase_sequencer_if.sv
// ============================================================================
// Module   : phase_sequencer_if
// Purpose  : Control and status bundle between a phase sequencer and its host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface phase_sequencer_if #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int COUNT_W    = 16
);
    logic                  run;
    logic                  halt_req;
    logic                  halt_instr;
    logic                  step_mode;
    logic                  step_req;
    logic                  mem_wait;
    logic [NUM_PHASES-1:0] skip_mask;
    logic [PHASE_W-1:0]    phase;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic                  phase_en;
    logic [1:0]            state;
    logic                  instr_done;
    logic [COUNT_W-1:0]    retire_count;

    modport master (
        output run, halt_req, halt_instr, step_mode, step_req, mem_wait, skip_mask,
        input  phase, phase_onehot, phase_en, state, instr_done, retire_count
    );

    modport slave (
        input  run, halt_req, halt_instr, step_mode, step_req, mem_wait, skip_mask,
        output phase, phase_onehot, phase_en, state, instr_done, retire_count
    );
endinterface

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Instruction phase sequencer with skip, stall, halt and single-step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int PHASE_W    = 3,
    parameter int COUNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    phase_sequencer_if.slave  bus
);

    localparam logic [1:0] S_HALTED = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    w_next_phase;
    logic [PHASE_W-1:0]    w_adv_phase;
    logic                  w_wrap;
    logic                  w_boundary;
    logic                  w_phase_en;
    logic                  w_set_pending;
    logic                  r_halt_pending;
    logic                  w_next_pending;
    logic                  r_instr_done;
    logic [COUNT_W-1:0]    r_retire_count;
    logic [NUM_PHASES-1:0] w_onehot;
    logic                  w_unused_skip0;

    // Phase 0 always executes, so its skip bit carries no meaning.
    assign w_unused_skip0 = bus.skip_mask[0];

    // Descending scan: the last hit is the smallest unskipped index above phase.
    always_comb begin
        w_adv_phase = '0;
        w_wrap      = 1'b1;
        for (int j = NUM_PHASES - 1; j >= 1; j--) begin
            if ((PHASE_W'(j) > r_phase) && !bus.skip_mask[j]) begin
                w_adv_phase = PHASE_W'(j);
                w_wrap      = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_HALTED;
            r_phase        <= '0;
            r_halt_pending <= 1'b0;
            r_instr_done   <= 1'b0;
            r_retire_count <= '0;
        end else begin
            r_state        <= w_next_state;
            r_phase        <= w_next_phase;
            r_halt_pending <= w_next_pending;
            r_instr_done   <= w_boundary;
            if (w_boundary) begin
                r_retire_count <= r_retire_count + COUNT_W'(1);
            end
        end
    end

    assign w_set_pending = (r_state != S_HALTED) &&
                           (bus.halt_req ||
                            (bus.halt_instr && w_phase_en && (r_phase == PHASE_W'(1))));

    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        w_boundary   = 1'b0;
        case (r_state)
            S_HALTED: begin
                if (bus.run) begin
                    w_next_state = S_RUN;
                    w_next_phase = '0;
                end
            end
            S_RUN: begin
                if (w_phase_en) begin
                    w_next_phase = w_adv_phase;
                    if (w_wrap) begin
                        w_boundary = 1'b1;
                        if (r_halt_pending) begin
                            w_next_state = S_HALTED;
                        end else if (bus.step_mode) begin
                            w_next_state = S_PAUSED;
                        end
                    end
                end
            end
            S_PAUSED: begin
                w_next_phase = '0;
                if (r_halt_pending || bus.halt_req) begin
                    w_next_state = S_HALTED;
                end else if (bus.step_req || !bus.step_mode) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_HALTED;
                w_next_phase = '0;
            end
        endcase

        // Entering HALTED consumes the pending halt, even if a new request arrives.
        w_next_pending = r_halt_pending | w_set_pending;
        if ((r_state != S_HALTED) && (w_next_state == S_HALTED)) begin
            w_next_pending = 1'b0;
        end
    end

    always_comb begin
        w_phase_en = (r_state == S_RUN) && !bus.mem_wait;
        w_onehot   = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            w_onehot[i] = (r_phase == PHASE_W'(i));
        end
    end

    assign bus.phase        = r_phase;
    assign bus.phase_onehot = w_onehot;
    assign bus.phase_en     = w_phase_en;
    assign bus.state        = r_state;
    assign bus.instr_done   = r_instr_done;
    assign bus.retire_count = r_retire_count;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module   : tb_phase_sequencer
// Purpose  : Directed self-checking bench for phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   pat3 [3] = '{0, 1, 4};

    always #5 clock = ~clock;

    phase_sequencer_if #(.NUM_PHASES(5), .PHASE_W(3), .COUNT_W(16)) ia ();
    phase_sequencer_if #(.NUM_PHASES(3), .PHASE_W(2), .COUNT_W(2))  ib ();

    phase_sequencer #(.NUM_PHASES(5), .PHASE_W(3), .COUNT_W(16)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ia.slave)
    );

    phase_sequencer #(.NUM_PHASES(3), .PHASE_W(2), .COUNT_W(2)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ib.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_a();
        ia.run = 1'b1;
        tick(1);
        ia.run = 1'b0;
    endtask

    initial begin
        ia.run = 0; ia.halt_req = 0; ia.halt_instr = 0; ia.step_mode = 0;
        ia.step_req = 0; ia.mem_wait = 0; ia.skip_mask = '0;
        ib.run = 0; ib.halt_req = 0; ib.halt_instr = 0; ib.step_mode = 0;
        ib.step_req = 0; ib.mem_wait = 0; ib.skip_mask = '0;

        // Reset values
        tick(2);
        check("rst_state",   32'(ia.state), 0);
        check("rst_phase",   32'(ia.phase), 0);
        check("rst_onehot",  32'(ia.phase_onehot), 1);
        check("rst_phase_en", 32'(ia.phase_en), 0);
        check("rst_done",    32'(ia.instr_done), 0);
        check("rst_count",   32'(ia.retire_count), 0);
        reset = 1'b1;
        tick(2);
        check("idle_halted", 32'(ia.state), 0);

        // Plain sequencing, then external halt
        start_a();
        check("run_state", 32'(ia.state), 1);
        check("run_phase", 32'(ia.phase), 0);
        check("run_en",    32'(ia.phase_en), 1);
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            check("seq_phase",  32'(ia.phase), 32'(k % 5));
            check("seq_onehot", 32'(ia.phase_onehot), 32'(1) << (k % 5));
            check("seq_done",   32'(ia.instr_done), 32'(k % 5 == 0));
        end
        check("seq_count", 32'(ia.retire_count), 3);
        ia.halt_req = 1'b1;
        tick(1);
        ia.halt_req = 1'b0;
        check("hreq_phase", 32'(ia.phase), 1);
        tick(3);
        check("hreq_run", 32'(ia.state), 1);
        tick(1);
        check("hreq_state", 32'(ia.state), 0);
        check("hreq_phase0", 32'(ia.phase), 0);
        check("hreq_done", 32'(ia.instr_done), 1);
        check("hreq_count", 32'(ia.retire_count), 4);
        tick(1);
        check("hreq_done_clr", 32'(ia.instr_done), 0);
        check("hreq_stay", 32'(ia.state), 0);

        // Skip phases 2 and 3
        ia.skip_mask = 5'b01100;
        start_a();
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("skip_phase", 32'(ia.phase), 32'(pat3[k % 3]));
            check("skip_done",  32'(ia.instr_done), 32'(k % 3 == 0));
        end
        check("skip_count", 32'(ia.retire_count), 6);
        ia.halt_req = 1'b1;
        tick(1);
        ia.halt_req = 1'b0;
        tick(2);
        check("skip_halt", 32'(ia.state), 0);
        check("skip_count2", 32'(ia.retire_count), 7);
        ia.skip_mask = '0;

        // Memory stall in phase 3 with a halt request arriving mid-stall
        start_a();
        tick(3);
        check("mw_phase3", 32'(ia.phase), 3);
        ia.mem_wait = 1'b1;
        #1;
        check("mw_en", 32'(ia.phase_en), 0);
        tick(1);
        check("mw_hold1", 32'(ia.phase), 3);
        ia.halt_req = 1'b1;
        tick(1);
        ia.halt_req = 1'b0;
        check("mw_hold2", 32'(ia.phase), 3);
        tick(1);
        check("mw_hold3", 32'(ia.phase), 3);
        tick(1);
        check("mw_hold4", 32'(ia.phase), 3);
        check("mw_state", 32'(ia.state), 1);
        ia.mem_wait = 1'b0;
        tick(1);
        check("mw_resume", 32'(ia.phase), 4);
        check("mw_run", 32'(ia.state), 1);
        tick(1);
        check("mw_done", 32'(ia.instr_done), 1);
        check("mw_halted", 32'(ia.state), 0);
        check("mw_count", 32'(ia.retire_count), 8);

        // HLT decoded in phase 1
        start_a();
        tick(1);
        check("hlt_phase1", 32'(ia.phase), 1);
        ia.halt_instr = 1'b1;
        tick(1);
        ia.halt_instr = 1'b0;
        check("hlt_phase2", 32'(ia.phase), 2);
        tick(2);
        check("hlt_phase4", 32'(ia.phase), 4);
        check("hlt_run", 32'(ia.state), 1);
        tick(1);
        check("hlt_state", 32'(ia.state), 0);
        check("hlt_phase0", 32'(ia.phase), 0);
        check("hlt_done", 32'(ia.instr_done), 1);
        check("hlt_count", 32'(ia.retire_count), 9);

        // Single-step mode
        ia.step_mode = 1'b1;
        start_a();
        tick(4);
        check("step_ph4", 32'(ia.phase), 4);
        tick(1);
        check("step_paused", 32'(ia.state), 2);
        check("step_done", 32'(ia.instr_done), 1);
        check("step_count1", 32'(ia.retire_count), 10);
        tick(3);
        check("step_hold", 32'(ia.state), 2);
        check("step_ph0", 32'(ia.phase), 0);
        check("step_en", 32'(ia.phase_en), 0);
        ia.step_req = 1'b1;
        tick(1);
        ia.step_req = 1'b0;
        check("step_run", 32'(ia.state), 1);
        tick(4);
        check("step_run2", 32'(ia.state), 1);
        tick(1);
        check("step_paused2", 32'(ia.state), 2);
        check("step_count2", 32'(ia.retire_count), 11);
        ia.halt_req = 1'b1;
        tick(1);
        ia.halt_req = 1'b0;
        check("step_halt", 32'(ia.state), 0);
        check("step_count3", 32'(ia.retire_count), 11);
        ia.step_mode = 1'b0;

        // All-ones mask: one-cycle instructions
        ia.skip_mask = 5'b11111;
        start_a();
        check("one_state", 32'(ia.state), 1);
        tick(1);
        check("one_phase", 32'(ia.phase), 0);
        check("one_done", 32'(ia.instr_done), 1);
        check("one_count1", 32'(ia.retire_count), 12);
        tick(1);
        check("one_count2", 32'(ia.retire_count), 13);
        ia.halt_req = 1'b1;
        tick(1);
        ia.halt_req = 1'b0;
        check("one_run", 32'(ia.state), 1);
        check("one_count3", 32'(ia.retire_count), 14);
        tick(1);
        check("one_halt", 32'(ia.state), 0);
        check("one_count4", 32'(ia.retire_count), 15);
        ia.skip_mask = '0;

        // Reset in the middle of an instruction
        start_a();
        tick(2);
        check("mid_phase2", 32'(ia.phase), 2);
        reset = 1'b0;
        #1;
        check("mid_state",  32'(ia.state), 0);
        check("mid_phase",  32'(ia.phase), 0);
        check("mid_onehot", 32'(ia.phase_onehot), 1);
        check("mid_en",     32'(ia.phase_en), 0);
        check("mid_done",   32'(ia.instr_done), 0);
        check("mid_count",  32'(ia.retire_count), 0);
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_halted", 32'(ia.state), 0);
        check("post_count",  32'(ia.retire_count), 0);

        // Three-phase instance with a 2-bit counter
        ib.run = 1'b1;
        tick(1);
        ib.run = 1'b0;
        check("b_state", 32'(ib.state), 1);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check("b_phase", 32'(ib.phase), 32'(k % 3));
            check("b_count", 32'(ib.retire_count), 32'((k / 3) % 4));
        end
        check("b_wrap_done", 32'(ib.instr_done), 1);
        check("b_wrap_zero", 32'(ib.retire_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
